toplayici_boru: RTL and testbench

TOPLAYICI_BORU -- requirements
Module: toplayici_boru

---
 rtl/toplayici_pkg.sv | 23 ++
 rtl/toplayici_dilim.sv | 40 ++++
 rtl/toplayici_boru.sv | 184 ++++++++++++++++++
 tb/tb_toplayici_boru.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/toplayici_pkg.sv
// rtl/toplayici_pkg.sv - shared defaults, parameter bounds and slice-width helper for the pipelined adder
package toplayici_pkg;

  localparam int VERI_BIT_VARSAYILAN = 32;
  localparam int ASAMA_VARSAYILAN    = 2;

  localparam int VERI_BIT_EN_AZ  = 8;
  localparam int VERI_BIT_EN_COK = 64;
  localparam int ASAMA_EN_AZ     = 1;
  localparam int ASAMA_EN_COK    = 4;

  // Per-operation control bits that travel down the pipe with the data
  typedef struct packed {
    logic cikar;
    logic imzali;
  } kontrol_t;

  // Each stage handles an equal, LSB-first share of the operand width
  function automatic int dilim_genisligi(input int veri_bit, input int asama);
    return veri_bit / asama;
  endfunction

endpackage

// File: rtl/toplayici_dilim.sv
// rtl/toplayici_dilim.sv - combinational Kogge-Stone slice adder with carry in/out
module toplayici_dilim #(
  parameter int GENISLIK = 16
) (
  input  logic [GENISLIK-1:0] a,
  input  logic [GENISLIK-1:0] b,
  input  logic                carry_giris,
  output logic [GENISLIK-1:0] toplam,
  output logic                carry_cikis
);

  localparam int SEVIYE = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;

  logic [GENISLIK-1:0] yay;
  logic [GENISLIK-1:0] g_l [SEVIYE+1];
  logic [GENISLIK-1:0] p_l [SEVIYE+1];
  logic [GENISLIK:0]   c;

  // Prefix tree: carry-in is folded into bit 0's generate so every
  // prefix output is directly the carry into the next bit
  always_comb begin
    yay     = a ^ b;
    g_l[0]  = a & b;
    p_l[0]  = yay;
    g_l[0][0] = (a[0] & b[0]) | (yay[0] & carry_giris);
    for (int l = 1; l <= SEVIYE; l++) begin
      g_l[l] = g_l[l-1];
      p_l[l] = p_l[l-1];
      for (int i = (1 << (l - 1)); i < GENISLIK; i++) begin
        g_l[l][i] = g_l[l-1][i] | (p_l[l-1][i] & g_l[l-1][i - (1 << (l - 1))]);
        p_l[l][i] = p_l[l-1][i] & p_l[l-1][i - (1 << (l - 1))];
      end
    end
    c[0]          = carry_giris;
    c[GENISLIK:1] = g_l[SEVIYE];
    toplam        = yay ^ c[GENISLIK-1:0];
    carry_cikis   = c[GENISLIK];
  end

endmodule

// File: rtl/toplayici_boru.sv
// rtl/toplayici_boru.sv - ASAMA-stage carry-segmented add/sub pipeline with valid/ready; saturation under TOPLAYICI_DOYUM_EN
module toplayici_boru
  import toplayici_pkg::*;
#(
  parameter int VERI_BIT = VERI_BIT_VARSAYILAN,
  parameter int ASAMA    = ASAMA_VARSAYILAN
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                giris_gecerli_i,
  output logic                giris_hazir_o,
  input  logic [VERI_BIT-1:0] islec0_i,
  input  logic [VERI_BIT-1:0] islec1_i,
  input  logic                carry_i,
  input  logic                cikar_i,
  input  logic                imzali_i,
`ifdef TOPLAYICI_DOYUM_EN
  input  logic                doyum_i,
`endif
  output logic                cikis_gecerli_o,
  input  logic                cikis_hazir_i,
  output logic [VERI_BIT-1:0] toplam_o,
  output logic                carry_o,
  output logic                tasma_o,
  output logic                sifir_o
);

  localparam int DW  = dilim_genisligi(VERI_BIT, ASAMA);
  localparam int SON = ASAMA - 1;
  localparam int MSB = VERI_BIT - 1;
  // Inter-stage register depth; the last stage writes the output registers directly
  localparam int NQ  = (ASAMA > 1) ? ASAMA - 1 : 1;

  if (ASAMA < ASAMA_EN_AZ || ASAMA > ASAMA_EN_COK ||
      VERI_BIT < VERI_BIT_EN_AZ || VERI_BIT > VERI_BIT_EN_COK ||
      (VERI_BIT % ASAMA) != 0) begin : g_param_hatasi
    $error("toplayici_boru: illegal VERI_BIT/ASAMA combination");
  end

  logic ilerle;

  // Stage inputs (what stage k sees this cycle)
  logic                v_d [ASAMA];
  logic [VERI_BIT-1:0] a_d [ASAMA];
  logic [VERI_BIT-1:0] b_d [ASAMA];
  logic [VERI_BIT-1:0] s_d [ASAMA];
  logic                c_d [ASAMA];
  kontrol_t            k_d [ASAMA];

  // Stage results before registering
  logic [VERI_BIT-1:0] s_n [ASAMA];
  logic [DW-1:0]       dilim_toplam [ASAMA];
  logic                dilim_carry  [ASAMA];

  // Inter-stage registers
  logic                v_q [NQ];
  logic [VERI_BIT-1:0] a_q [NQ];
  logic [VERI_BIT-1:0] b_q [NQ];
  logic [VERI_BIT-1:0] s_q [NQ];
  logic                c_q [NQ];
  kontrol_t            k_q [NQ];

`ifdef TOPLAYICI_DOYUM_EN
  logic                doyum_d [ASAMA];
  logic                doyum_q [NQ];
`endif

  logic [VERI_BIT-1:0] son_toplam;
  logic                son_carry;
  logic                son_tasma;

  // A single global stall: everything moves only when the output slot frees up
  assign ilerle        = !cikis_gecerli_o || cikis_hazir_i;
  assign giris_hazir_o = ilerle;

  // Stage 0 takes the ports (with B inverted for subtract); later stages take the previous register
  always_comb begin
    v_d[0]        = giris_gecerli_i;
    a_d[0]        = islec0_i;
    b_d[0]        = cikar_i ? ~islec1_i : islec1_i;
    s_d[0]        = '0;
    c_d[0]        = carry_i ^ cikar_i;
    k_d[0].cikar  = cikar_i;
    k_d[0].imzali = imzali_i;
`ifdef TOPLAYICI_DOYUM_EN
    doyum_d[0]    = doyum_i;
`endif
    for (int k = 1; k < ASAMA; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      c_d[k] = c_q[k-1];
      k_d[k] = k_q[k-1];
`ifdef TOPLAYICI_DOYUM_EN
      doyum_d[k] = doyum_q[k-1];
`endif
    end
  end

  for (genvar k = 0; k < ASAMA; k++) begin : g_dilim
    toplayici_dilim #(
      .GENISLIK (DW)
    ) u_dilim (
      .a           (a_d[k][k*DW +: DW]),
      .b           (b_d[k][k*DW +: DW]),
      .carry_giris (c_d[k]),
      .toplam      (dilim_toplam[k]),
      .carry_cikis (dilim_carry[k])
    );
  end

  // Merge each stage's freshly computed slice into the partial sum it carries
  always_comb begin
    for (int k = 0; k < ASAMA; k++) begin
      s_n[k]               = s_d[k];
      s_n[k][k*DW +: DW]   = dilim_toplam[k];
    end
  end

  // Last stage: overflow flag from operand/result signs or raw carry, then optional clamp
  always_comb begin
    son_carry  = dilim_carry[SON];
    if (k_d[SON].imzali) begin
      son_tasma = (a_d[SON][MSB] == b_d[SON][MSB]) && (s_n[SON][MSB] != a_d[SON][MSB]);
    end else begin
      son_tasma = (son_carry != k_d[SON].cikar);
    end
    son_toplam = s_n[SON];
`ifdef TOPLAYICI_DOYUM_EN
    if (doyum_d[SON] && son_tasma) begin
      if (k_d[SON].imzali) begin
        son_toplam = a_d[SON][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end else begin
        son_toplam = k_d[SON].cikar ? '0 : '1;
      end
    end
`endif
  end

  // Pipeline registers; data only loads with a valid slot so idle outputs keep their last value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NQ; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        k_q[k] <= '0;
`ifdef TOPLAYICI_DOYUM_EN
        doyum_q[k] <= 1'b0;
`endif
      end
      cikis_gecerli_o <= 1'b0;
      toplam_o        <= '0;
      carry_o         <= 1'b0;
      tasma_o         <= 1'b0;
      sifir_o         <= 1'b0;
    end else if (ilerle) begin
      for (int k = 0; k < SON; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_n[k];
          c_q[k] <= dilim_carry[k];
          k_q[k] <= k_d[k];
`ifdef TOPLAYICI_DOYUM_EN
          doyum_q[k] <= doyum_d[k];
`endif
        end
      end
      cikis_gecerli_o <= v_d[SON];
      if (v_d[SON]) begin
        toplam_o <= son_toplam;
        carry_o  <= son_carry;
        tasma_o  <= son_tasma;
        sifir_o  <= (son_toplam == '0);
      end
    end
  end

endmodule

// File: tb/tb_toplayici_boru.sv
// tb/tb_toplayici_boru.sv - directed and randomized self-checking bench for toplayici_boru (honours TOPLAYICI_DOYUM_EN)
module tb_toplayici_boru;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-bit / 2-stage instance for directed vectors
  logic        a_gv, a_gh, a_cin, a_sub, a_sgn, a_cv, a_ch, a_c, a_t, a_z;
  logic [31:0] a_x, a_y, a_s;
`ifdef TOPLAYICI_DOYUM_EN
  logic        a_dy;
`endif

  // 16-bit / 4-stage instance for the randomized run
  logic        b_gv, b_gh, b_cin, b_sub, b_sgn, b_cv, b_ch, b_c, b_t, b_z;
  logic [15:0] b_x, b_y, b_s;
`ifdef TOPLAYICI_DOYUM_EN
  logic        b_dy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  toplayici_boru #(.VERI_BIT(32), .ASAMA(2)) u_dut_a (
    .clk_i           (clk),
    .rst_i           (rst),
    .giris_gecerli_i (a_gv),
    .giris_hazir_o   (a_gh),
    .islec0_i        (a_x),
    .islec1_i        (a_y),
    .carry_i         (a_cin),
    .cikar_i         (a_sub),
    .imzali_i        (a_sgn),
`ifdef TOPLAYICI_DOYUM_EN
    .doyum_i         (a_dy),
`endif
    .cikis_gecerli_o (a_cv),
    .cikis_hazir_i   (a_ch),
    .toplam_o        (a_s),
    .carry_o         (a_c),
    .tasma_o         (a_t),
    .sifir_o         (a_z)
  );

  toplayici_boru #(.VERI_BIT(16), .ASAMA(4)) u_dut_b (
    .clk_i           (clk),
    .rst_i           (rst),
    .giris_gecerli_i (b_gv),
    .giris_hazir_o   (b_gh),
    .islec0_i        (b_x),
    .islec1_i        (b_y),
    .carry_i         (b_cin),
    .cikar_i         (b_sub),
    .imzali_i        (b_sgn),
`ifdef TOPLAYICI_DOYUM_EN
    .doyum_i         (b_dy),
`endif
    .cikis_gecerli_o (b_cv),
    .cikis_hazir_i   (b_ch),
    .toplam_o        (b_s),
    .carry_o         (b_c),
    .tasma_o         (b_t),
    .sifir_o         (b_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 16-bit instance: plain integer arithmetic and range tests
  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic cin, input logic sub, input logic sgn);
    int ur, sr;
    logic [15:0] s;
    logic c, t;
    if (!sub) begin
      ur = int'(x) + int'(y) + int'(cin);
      sr = int'($signed(x)) + int'($signed(y)) + int'(cin);
      c  = (ur > 65535);
    end else begin
      ur = int'(x) - int'(y) - int'(cin);
      sr = int'($signed(x)) - int'($signed(y)) - int'(cin);
      c  = (ur >= 0);
    end
    s = ur[15:0];
    t = sgn ? (sr > 32767 || sr < -32768) : (sub ? !c : c);
    return {s, c, t, (s == 16'h0)};
  endfunction

  // One isolated operation on instance A: latency, result, flags, then idle hold
  task automatic a_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic cin, input logic sub, input logic sgn,
                      input logic [31:0] es, input logic ec, input logic et, input logic ez);
    a_gv = 1'b1; a_x = x; a_y = y; a_cin = cin; a_sub = sub; a_sgn = sgn; a_ch = 1'b1;
    step();
    a_gv = 1'b0;
    check({tag, "/lat"}, a_cv, 1'b0);
    step();
    check({tag, "/v"}, a_cv, 1'b1);
    check({tag, "/sum"}, a_s, es);
    check({tag, "/flags"}, {a_c, a_t, a_z}, {ec, et, ez});
    step();
    check({tag, "/hold"}, {a_cv, a_s}, {1'b0, es});
  endtask

  logic [31:0] sx [4];
  logic [31:0] se [4];
  logic [18:0] rq [$];
  logic [18:0] cur, stv;
  logic        stl;
  int pi, oi, nst, acc, got;

  initial begin
    rst = 1'b1;
    a_gv = 0; a_x = 0; a_y = 0; a_cin = 0; a_sub = 0; a_sgn = 0; a_ch = 1;
    b_gv = 0; b_x = 0; b_y = 0; b_cin = 0; b_sub = 0; b_sgn = 0; b_ch = 1;
`ifdef TOPLAYICI_DOYUM_EN
    a_dy = 0; b_dy = 0;
`endif
    step();
    step();
    rst = 1'b0;
    check("rst/hazir", {a_gh, b_gh}, 2'b11);
    check("rst/v", {a_cv, b_cv}, 2'b00);
    check("rst/sum", a_s, 32'h0);
    check("rst/flags", {a_c, a_t, a_z}, 3'b000);

    a_op("ovf_u",  32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 1, 1);
    a_op("sub_s",  32'h0000_0005, 32'h0000_0007, 0, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
    a_op("sub_u",  32'h0000_0005, 32'h0000_0007, 0, 1, 0, 32'hFFFF_FFFE, 0, 1, 0);
    a_op("ovf_s",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h8000_0000, 0, 1, 0);
    a_op("ovf_n",  32'h8000_0000, 32'h0000_0001, 0, 1, 1, 32'h7FFF_FFFF, 1, 1, 0);
    a_op("cin_x",  32'h0000_FFFF, 32'h0000_0000, 1, 0, 0, 32'h0001_0000, 0, 0, 0);
    a_op("brw",    32'h0000_000A, 32'h0000_0003, 1, 1, 0, 32'h0000_0006, 1, 0, 0);
`ifdef TOPLAYICI_DOYUM_EN
    a_dy = 1'b1;
    a_op("sat_s",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0);
    a_op("sat_u",  32'h0000_0005, 32'h0000_0007, 0, 1, 0, 32'h0000_0000, 0, 1, 1);
    a_dy = 1'b0;
`endif

    // Four back-to-back adds with the consumer stalling for three cycles
    sx[0] = 32'h1000_FFFF; se[0] = 32'h1001_0000;
    sx[1] = 32'h2000_FFFF; se[1] = 32'h2001_0000;
    sx[2] = 32'h3000_FFFF; se[2] = 32'h3001_0000;
    sx[3] = 32'h4000_FFFF; se[3] = 32'h4001_0000;
    pi = 0; oi = 0; nst = 0;
    for (int cyc = 0; cyc < 40 && oi < 4; cyc++) begin
      a_ch = !(cyc >= 2 && cyc <= 4);
      a_gv = (pi < 4);
      if (pi < 4) begin
        a_x = sx[pi]; a_y = 32'h1; a_cin = 0; a_sub = 0; a_sgn = 0;
      end
      #1;
      if (a_cv && !a_ch) begin
        nst++;
        check("strm/stall_hazir", a_gh, 1'b0);
        check("strm/held", a_s, se[oi]);
      end
      if (a_cv && a_ch) begin
        check("strm/res", a_s, se[oi]);
        oi++;
      end
      if (a_gv && a_gh) pi++;
      step();
    end
    a_gv = 0; a_ch = 1;
    check("strm/count", oi, 4);
    check("strm/nstall", nst, 3);
    step();
    step();

    // Reset with two operations in flight
    a_gv = 1; a_x = 32'hFFFF_FFFF; a_y = 32'hFFFF_FFFF; a_cin = 0; a_sub = 0; a_sgn = 0; a_ch = 1;
    step();
    a_x = 32'h1; a_y = 32'h2;
    step();
    check("rst2/inflight", {a_cv, a_s, a_c, a_t, a_z}, {1'b1, 32'hFFFF_FFFE, 3'b110});
    a_gv = 0; rst = 1;
    step();
    rst = 0;
    check("rst2/out", {a_cv, a_s, a_c, a_t, a_z}, 36'h0);
    for (int i = 0; i < 4; i++) begin
      check("rst2/stale", a_cv, 1'b0);
      step();
    end

    // 16-bit / 4-stage: random operations against the integer model with random stalls
    acc = 0; got = 0; stl = 0; stv = '0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      b_gv  = (acc < 10000) && ($urandom_range(0, 3) != 0);
      b_x   = 16'($urandom);
      b_y   = 16'($urandom);
      b_cin = 1'($urandom);
      b_sub = 1'($urandom);
      b_sgn = 1'($urandom);
      b_ch  = ($urandom_range(0, 9) < 7);
      #1;
      cur = {b_s, b_c, b_t, b_z};
      if (stl) check("rnd/hold", {b_cv, cur}, {1'b1, stv});
      if (b_gv && b_gh) begin
        rq.push_back(model16(b_x, b_y, b_cin, b_sub, b_sgn));
        acc++;
      end
      if (b_cv && b_ch) begin
        if (rq.size() == 0) check("rnd/extra", 1'b1, 1'b0);
        else check("rnd/res", cur, rq.pop_front());
        got++;
      end
      stl = b_cv && !b_ch;
      stv = cur;
      step();
    end
    b_gv = 0;
    check("rnd/count", got, 10000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
